// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: word width, opcodes,
// fetch FSM states and the IF/ID register payload.
package core_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADDI = 4'b1001,
    OP_LD   = 4'b1010,
    OP_ST   = 4'b1011,
    OP_BZ   = 4'b1100
  } opcode_e;

  localparam logic [WORD_W-1:0] BUBBLE_WORD = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc1;
    logic              valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, pipeline controls from
// the hazard and branch units, IF/ID outputs to decode, and statistics.
interface fetch_stage_if;
  import core_pkg::*;

  logic [WORD_W-1:0] pc_out;
  logic [WORD_W-1:0] instr_out;
  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] ifid_instr;
  logic [WORD_W-1:0] ifid_pc1;
  logic              ifid_valid;
  logic              halted;
  logic [WORD_W-1:0] fetch_count;
  logic [WORD_W-1:0] bubble_count;

  modport master (
    output pc_out, ifid_instr, ifid_pc1, ifid_valid, halted, fetch_count, bubble_count,
    input  instr_out, stall, redirect, redirect_pc
  );

  modport slave (
    input  pc_out, ifid_instr, ifid_pc1, ifid_valid, halted, fetch_count, bubble_count,
    output instr_out, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/ifid_reg.sv
// Pipeline stage register with load, hold and bubble-insert controls.
// A bubble replaces the instruction with NOP_WORD and clears valid but keeps pc1.
module ifid_reg
  import core_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = BUBBLE_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc1_i,
  output ifid_t             q_o
);

  ifid_t stage_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{instr: NOP_WORD, pc1: '0, valid: 1'b0};
    end else if (bubble_i) begin
      stage_q.instr <= NOP_WORD;
      stage_q.valid <= 1'b0;
    end else if (load_i) begin
      stage_q <= '{instr: instr_i, pc1: pc1_i, valid: 1'b1};
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT FSM and IF/ID capture.
// Define FETCH_STATS_EN to build the saturating fetch/bubble counters.
module fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned       PROG_LEN = 40,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_WORD = BUBBLE_WORD
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  // One extra bit so PROG_LEN = 65536 still compares against PC+1.
  localparam logic [WORD_W:0] PROG_END = PROG_LEN[WORD_W:0];

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W:0]   pc_inc;
  logic              ifid_load;
  logic              ifid_bubble;
  ifid_t             ifid_q;

  assign pc_inc = {1'b0, pc_q} + {{WORD_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = ({1'b0, RESET_PC} >= PROG_END) ? HALT : RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          pc_d        = bus.redirect_pc;
          ifid_bubble = 1'b1;
          // A target outside the image parks the stage instead of fetching past it.
          if ({1'b0, bus.redirect_pc} >= PROG_END) state_d = HALT;
        end else if (!bus.stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_inc[WORD_W-1:0];
          if (pc_inc == PROG_END) state_d = HALT;
        end
      end
      HALT: begin
        if (bus.redirect) begin
          pc_d        = bus.redirect_pc;
          ifid_bubble = 1'b1;
          if ({1'b0, bus.redirect_pc} < PROG_END) state_d = RUN;
        end else if (!bus.stall) begin
          ifid_bubble = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .instr_i  (bus.instr_out),
    .pc1_i    (pc_inc[WORD_W-1:0]),
    .q_o      (ifid_q)
  );

  assign bus.pc_out     = pc_q;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_pc1   = ifid_q.pc1;
  assign bus.ifid_valid = ifid_q.valid;
  assign bus.halted     = (state_q == HALT);

`ifdef FETCH_STATS_EN
  logic [WORD_W-1:0] fetch_cnt_q;
  logic [WORD_W-1:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ifid_load && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (ifid_bubble && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bus.fetch_count  = fetch_cnt_q;
  assign bus.bubble_count = bubble_cnt_q;
`else
  assign bus.fetch_count  = '0;
  assign bus.bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected
// post-edge state into a scoreboard that a monitor pops after each rising edge.
module tb_fetch_stage;
  import core_pkg::*;

  localparam int unsigned PROG_LEN = 40;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .PROG_LEN (PROG_LEN),
    .RESET_PC (RESET_PC),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {4'b1001, a[11:0]} ^ 16'h0A50;
  endfunction

  assign bus.instr_out = mem_word(bus.pc_out);

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
    logic        halted;
    logic [15:0] fc;
    logic [15:0] bc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (0 = boot, 1 = run, 2 = halt)
  int          m_state;
  logic [15:0] m_pc, m_instr, m_pc1, m_fc, m_bc;
  logic        m_valid;

  task automatic model_reset();
    m_state = 0;
    m_pc    = RESET_PC;
    m_instr = NOP_WORD;
    m_pc1   = 16'd0;
    m_valid = 1'b0;
    m_fc    = 16'd0;
    m_bc    = 16'd0;
    sb.delete();
  endtask

  task automatic model_advance(input logic st, input logic rd, input logic [15:0] rpc);
    logic [15:0] ins;
    bit          ld;
    bit          bub;
    exp_t        e;
    ins = mem_word(m_pc);
    ld  = 0;
    bub = 0;
    case (m_state)
      0: m_state = (int'(RESET_PC) >= int'(PROG_LEN)) ? 2 : 1;
      1: begin
        if (rd) begin
          m_pc = rpc;
          bub  = 1;
          if (int'(rpc) >= int'(PROG_LEN)) m_state = 2;
        end else if (!st) begin
          ld      = 1;
          m_instr = ins;
          m_pc1   = m_pc + 16'd1;
          m_pc    = m_pc + 16'd1;
          if (int'(m_pc) == int'(PROG_LEN)) m_state = 2;
        end
      end
      default: begin
        if (rd) begin
          m_pc = rpc;
          bub  = 1;
          if (int'(rpc) < int'(PROG_LEN)) m_state = 1;
        end else if (!st) begin
          bub = 1;
        end
      end
    endcase
    if (bub) begin
      m_instr = NOP_WORD;
      m_valid = 1'b0;
    end
    if (ld) m_valid = 1'b1;
`ifdef FETCH_STATS_EN
    if (ld && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    if (bub && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
`endif
    e.pc     = m_pc;
    e.instr  = m_instr;
    e.pc1    = m_pc1;
    e.valid  = m_valid;
    e.halted = (m_state == 2);
    e.fc     = m_fc;
    e.bc     = m_bc;
    sb.push_back(e);
  endtask

  // Drive one cycle on the falling edge; returns after the monitor has compared.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    model_advance(st, rd, rpc);
    @(posedge clk);
    #2;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.pc_out !== e.pc) begin
        failures++;
        $display("FAIL sb_pc: got %h expected %h", bus.pc_out, e.pc);
      end
      checks++;
      if (bus.ifid_instr !== e.instr) begin
        failures++;
        $display("FAIL sb_instr: got %h expected %h", bus.ifid_instr, e.instr);
      end
      checks++;
      if (bus.ifid_pc1 !== e.pc1) begin
        failures++;
        $display("FAIL sb_pc1: got %h expected %h", bus.ifid_pc1, e.pc1);
      end
      checks++;
      if (bus.ifid_valid !== e.valid) begin
        failures++;
        $display("FAIL sb_valid: got %b expected %b", bus.ifid_valid, e.valid);
      end
      checks++;
      if (bus.halted !== e.halted) begin
        failures++;
        $display("FAIL sb_halted: got %b expected %b", bus.halted, e.halted);
      end
      checks++;
      if ({bus.fetch_count, bus.bubble_count} !== {e.fc, e.bc}) begin
        failures++;
        $display("FAIL sb_counts: got %0d/%0d expected %0d/%0d",
                 bus.fetch_count, bus.bubble_count, e.fc, e.bc);
      end
    end
  end

  // Asynchronous reset from any point in the cycle, released after one edge.
  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc1} !== {RESET_PC, NOP_WORD, 16'd0}) begin
      failures++;
      $display("FAIL reset_regs: got pc=%h instr=%h pc1=%h expected %h %h 0000",
               bus.pc_out, bus.ifid_instr, bus.ifid_pc1, RESET_PC, NOP_WORD);
    end
    checks++;
    if ({bus.ifid_valid, bus.halted} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got valid=%b halted=%b expected 0 0", bus.ifid_valid, bus.halted);
    end
    checks++;
    if ({bus.fetch_count, bus.bubble_count} !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.fetch_count, bus.bubble_count);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    step(0, 0, 16'd0);
    checks++;
    if ({bus.pc_out, bus.ifid_valid} !== {16'd0, 1'b0}) begin
      failures++;
      $display("FAIL boot_edge: got pc=%h valid=%b expected 0000 0", bus.pc_out, bus.ifid_valid);
    end
    step(0, 0, 16'd0);
    checks++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc1} !== {1'b1, mem_word(16'd0), 16'd1}) begin
      failures++;
      $display("FAIL first_fetch: got valid=%b instr=%h pc1=%h expected 1 %h 0001",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_pc1, mem_word(16'd0));
    end
    step(0, 0, 16'd0);
    step(0, 0, 16'd0);
    checks++;
    if ({bus.pc_out, bus.ifid_instr} !== {16'd3, mem_word(16'd2)}) begin
      failures++;
      $display("FAIL seq_pc3: got pc=%h instr=%h expected 0003 %h",
               bus.pc_out, bus.ifid_instr, mem_word(16'd2));
    end
  endtask

  task automatic test_stall();
    logic [15:0] fc_before;
    fc_before = m_fc;
    for (int i = 0; i < 3; i++) step(1, 0, 16'd0);
    checks++;
    if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid} !== {16'd3, mem_word(16'd2), 1'b1}) begin
      failures++;
      $display("FAIL stall_hold: got pc=%h instr=%h valid=%b expected 0003 %h 1",
               bus.pc_out, bus.ifid_instr, bus.ifid_valid, mem_word(16'd2));
    end
    checks++;
    if (bus.fetch_count !== fc_before) begin
      failures++;
      $display("FAIL stall_fcount: got %0d expected %0d", bus.fetch_count, fc_before);
    end
    step(0, 0, 16'd0);
    checks++;
    if ({bus.pc_out, bus.ifid_instr} !== {16'd4, mem_word(16'd3)}) begin
      failures++;
      $display("FAIL stall_resume: got pc=%h instr=%h expected 0004 %h",
               bus.pc_out, bus.ifid_instr, mem_word(16'd3));
    end
  endtask

  task automatic test_redirect();
    int budget;
    budget = 20;
    while (bus.pc_out != 16'd10 && budget > 0) begin
      step(0, 0, 16'd0);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL redirect_reach_pc10: got pc=%h expected 000a within budget", bus.pc_out);
    end
    step(0, 1, 16'd37);
    checks++;
    if ({bus.pc_out, bus.ifid_valid, bus.ifid_instr} !== {16'd37, 1'b0, NOP_WORD}) begin
      failures++;
      $display("FAIL redirect_bubble: got pc=%h valid=%b instr=%h expected 0025 0 %h",
               bus.pc_out, bus.ifid_valid, bus.ifid_instr, NOP_WORD);
    end
    step(0, 0, 16'd0);
    checks++;
    if ({bus.ifid_instr, bus.ifid_pc1, bus.ifid_valid} !== {mem_word(16'd37), 16'd38, 1'b1}) begin
      failures++;
      $display("FAIL redirect_target: got instr=%h pc1=%h valid=%b expected %h 0026 1",
               bus.ifid_instr, bus.ifid_pc1, bus.ifid_valid, mem_word(16'd37));
    end
  endtask

  task automatic test_redirect_stall();
    step(1, 1, 16'd5);
    checks++;
    if ({bus.pc_out, bus.ifid_valid, bus.ifid_instr} !== {16'd5, 1'b0, NOP_WORD}) begin
      failures++;
      $display("FAIL redirect_over_stall: got pc=%h valid=%b instr=%h expected 0005 0 %h",
               bus.pc_out, bus.ifid_valid, bus.ifid_instr, NOP_WORD);
    end
  endtask

  task automatic test_halt();
    int budget;
    step(0, 1, 16'd34);
    budget = 12;
    while (bus.halted !== 1'b1 && budget > 0) begin
      step(0, 0, 16'd0);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL halt_reach: got halted=%b expected 1 within budget", bus.halted);
    end
    checks++;
    if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid} !== {16'd40, mem_word(16'd39), 1'b1}) begin
      failures++;
      $display("FAIL halt_last: got pc=%h instr=%h valid=%b expected 0028 %h 1",
               bus.pc_out, bus.ifid_instr, bus.ifid_valid, mem_word(16'd39));
    end
    step(0, 0, 16'd0);
    step(0, 0, 16'd0);
    checks++;
    if ({bus.pc_out, bus.ifid_valid, bus.halted} !== {16'd40, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL halt_drain: got pc=%h valid=%b halted=%b expected 0028 0 1",
               bus.pc_out, bus.ifid_valid, bus.halted);
    end
    step(0, 1, 16'd0);
    checks++;
    if ({bus.pc_out, bus.halted} !== {16'd0, 1'b0}) begin
      failures++;
      $display("FAIL halt_restart: got pc=%h halted=%b expected 0000 0", bus.pc_out, bus.halted);
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_fc, exp_bc;
    test_reset();
    step(0, 0, 16'd0);
    step(0, 1, 16'd34);
    for (int i = 0; i < 6; i++) step(0, 0, 16'd0);
    step(0, 0, 16'd0);
    step(0, 0, 16'd0);
`ifdef FETCH_STATS_EN
    exp_fc = 16'd6;
    exp_bc = 16'd3;
`else
    exp_fc = 16'd0;
    exp_bc = 16'd0;
`endif
    checks++;
    if (bus.fetch_count !== exp_fc) begin
      failures++;
      $display("FAIL stats_fetch: got %0d expected %0d", bus.fetch_count, exp_fc);
    end
    checks++;
    if (bus.bubble_count !== exp_bc) begin
      failures++;
      $display("FAIL stats_bubble: got %0d expected %0d", bus.bubble_count, exp_bc);
    end
  endtask

  task automatic test_back_to_back();
    logic st, rd;
    test_reset();
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      step(st, rd, 16'($urandom_range(0, PROG_LEN - 1)));
    end
  endtask

  task automatic test_async_reset_midrun();
    step(0, 0, 16'd0);
    step(0, 0, 16'd0);
    test_reset();
    step(0, 0, 16'd0);
    step(0, 0, 16'd0);
    checks++;
    if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid} !== {16'd1, mem_word(16'd0), 1'b1}) begin
      failures++;
      $display("FAIL reset_refetch: got pc=%h instr=%h valid=%b expected 0001 %h 1",
               bus.pc_out, bus.ifid_instr, bus.ifid_valid, mem_word(16'd0));
    end
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_stats();
    test_back_to_back();
    test_async_reset_midrun();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
